// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and helpers for the inter-stage pipeline register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Bit offset of payload field k when each field is w bits wide.
  function automatic int unsigned field_sel(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter; sticks at all-ones, cleared only by reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush, optional two-entry skid buffer
// and a saturating downstream-stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FIELDS = 3,
  parameter int SKID_EN    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] data_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] data_o,
  output logic [CNT_WIDTH-1:0]             stall_cnt_o
);

  localparam int PW = NUM_FIELDS * DATA_WIDTH;

  pipe_state_t   state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          in_xfer, out_xfer;

  assign valid_o  = (state_q != EMPTY);
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;
  assign data_o   = main_q;

  // With the skid buffer, ready_o is decoded purely from the state flop so
  // that ready_i never reaches it combinationally.
  generate
    if (SKID_EN != 0) begin : g_skid_rdy
      assign ready_o = (state_q != FULL);
    end else begin : g_comb_rdy
      assign ready_o = ready_i | ~valid_o;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Data regs keep their contents; only occupancy is dropped.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = data_i;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && (out_xfer || (SKID_EN == 0))) begin
            main_d = data_i;
          end else if (in_xfer) begin
            skid_d  = data_i;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (valid_o & ~ready_i),
    .count_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid variant (4-bit stall counter) and pass-through variant.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 8;
  localparam int NF = 3;
  localparam int PW = DW * NF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // skid instance
  logic          a_flush, a_vld_i, a_rdy_o, a_vld_o, a_rdy_i;
  logic [PW-1:0] a_dat_i, a_dat_o;
  logic [3:0]    a_cnt;
  // combinational-ready instance
  logic          b_flush, b_vld_i, b_rdy_o, b_vld_o, b_rdy_i;
  logic [PW-1:0] b_dat_i, b_dat_o;
  logic [15:0]   b_cnt;

  pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .SKID_EN(1), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush_i(a_flush), .valid_i(a_vld_i), .ready_o(a_rdy_o),
    .data_i(a_dat_i), .valid_o(a_vld_o), .ready_i(a_rdy_i), .data_o(a_dat_o),
    .stall_cnt_o(a_cnt));

  pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .SKID_EN(0), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .flush_i(b_flush), .valid_i(b_vld_i), .ready_o(b_rdy_o),
    .data_i(b_dat_i), .valid_o(b_vld_o), .ready_i(b_rdy_i), .data_o(b_dat_o),
    .stall_cnt_o(b_cnt));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rep(input logic [DW-1:0] v);
    return {NF{v}};
  endfunction

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] fld;
    rst_n = 1'b0;
    a_flush = 0; a_vld_i = 0; a_rdy_i = 0; a_dat_i = '0;
    b_flush = 0; b_vld_i = 0; b_rdy_i = 0; b_dat_i = '0;
    #12;
    chk("rst_valid", a_vld_o, 1'b0);
    chk("rst_ready", a_rdy_o, 1'b1);
    chk("rst_data",  a_dat_o, '0);
    chk("rst_cnt",   a_cnt, 4'd0);
    step();
    rst_n = 1'b1;
    step();

    // streaming
    a_vld_i = 1; a_rdy_i = 1; a_dat_i = rep(8'h01);
    #1 chk("lat_pre_valid", a_vld_o, 1'b0);
    step(); chk("str_v1", a_vld_o, 1'b1); chk("str_d1", a_dat_o, rep(8'h01));
    a_dat_i = rep(8'h02);
    step(); chk("str_d2", a_dat_o, rep(8'h02));
    a_dat_i = rep(8'h03);
    step(); chk("str_d3", a_dat_o, rep(8'h03));
    fld = a_dat_o[field_sel(1, DW) +: DW];
    chk("str_field1", fld, 8'h03);
    a_vld_i = 0;
    step(); chk("str_drain", a_vld_o, 1'b0); chk("str_cnt", a_cnt, 4'd0);

    // skid fill
    a_rdy_i = 0; a_vld_i = 1; a_dat_i = rep(8'h0A);
    step(); chk("skid_busy_rdy", a_rdy_o, 1'b1); chk("skid_d_A", a_dat_o, rep(8'h0A));
    a_dat_i = rep(8'h0B);
    step(); chk("skid_full_rdy", a_rdy_o, 1'b0); chk("skid_hold_A", a_dat_o, rep(8'h0A));
    a_vld_i = 0;
    step(); chk("skid_hold2_A", a_dat_o, rep(8'h0A)); chk("skid_cnt", a_cnt, 4'd2);
    a_rdy_i = 1;
    step(); chk("skid_out_B", a_dat_o, rep(8'h0B)); chk("skid_rdy_back", a_rdy_o, 1'b1);
    chk("skid_v_B", a_vld_o, 1'b1);
    step(); chk("skid_empty", a_vld_o, 1'b0); chk("skid_cnt2", a_cnt, 4'd2);

    // flush from FULL
    a_rdy_i = 0; a_vld_i = 1; a_dat_i = rep(8'h0A);
    step();
    a_dat_i = rep(8'h0B);
    step(); chk("fl_full", a_rdy_o, 1'b0);
    a_flush = 1; a_dat_i = rep(8'h0C);
    step(); chk("fl_valid", a_vld_o, 1'b0); chk("fl_ready", a_rdy_o, 1'b1);
    chk("fl_cnt_kept", a_cnt, 4'd4);
    a_flush = 0; a_vld_i = 0; a_rdy_i = 1;
    step(); chk("fl_stay_empty", a_vld_o, 1'b0);
    // next entry delivered must be the new one, never B or C
    a_vld_i = 1; a_dat_i = rep(8'h0F);
    step(); chk("fl_next_v", a_vld_o, 1'b1); chk("fl_next_d", a_dat_o, rep(8'h0F));
    a_vld_i = 0;
    step(); chk("fl_next_gone", a_vld_o, 1'b0);

    // flush from BUSY discards a same-cycle in_xfer
    a_rdy_i = 0; a_vld_i = 1; a_dat_i = rep(8'h0A);
    step();
    a_flush = 1; a_dat_i = rep(8'h0C);
    step(); chk("flb_valid", a_vld_o, 1'b0); chk("flb_cnt", a_cnt, 4'd5);
    a_flush = 0; a_vld_i = 0;
    step(); chk("flb_empty", a_vld_o, 1'b0);

    // saturation
    a_vld_i = 1; a_dat_i = rep(8'h0D);
    step(); a_vld_i = 0;
    chk("sat_start", a_cnt, 4'd5);
    for (int i = 0; i < 5; i++) step();
    chk("sat_mid", a_cnt, 4'd10);
    for (int i = 0; i < 15; i++) step();
    chk("sat_top", a_cnt, 4'd15);
    step(); step();
    chk("sat_hold", a_cnt, 4'd15);
    chk("sat_data", a_dat_o, rep(8'h0D));

    // async reset while FULL
    a_vld_i = 1; a_dat_i = rep(8'h0E);
    step(); a_vld_i = 0;
    chk("ar_full", a_rdy_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", a_vld_o, 1'b0);
    chk("ar_ready", a_rdy_o, 1'b1);
    chk("ar_cnt", a_cnt, 4'd0);
    a_rdy_i = 1;
    step(); rst_n = 1'b1;
    step();

    // pass-through variant: combinational ready
    b_vld_i = 1; b_rdy_i = 1; b_dat_i = rep(8'h01);
    #1 chk("b_rdy_empty", b_rdy_o, 1'b1);
    step(); chk("b_d1", b_dat_o, rep(8'h01)); chk("b_v1", b_vld_o, 1'b1);
    b_rdy_i = 0; b_dat_i = rep(8'h02);
    #1 chk("b_rdy_comb0", b_rdy_o, 1'b0);
    step(); chk("b_hold1", b_dat_o, rep(8'h01)); chk("b_hold_v", b_vld_o, 1'b1);
    b_rdy_i = 1;
    #1 chk("b_rdy_comb1", b_rdy_o, 1'b1);
    step(); chk("b_d2", b_dat_o, rep(8'h02));
    b_rdy_i = 0;
    #1 chk("b_rdy_comb0b", b_rdy_o, 1'b0);
    step(); chk("b_hold2", b_dat_o, rep(8'h02));
    b_rdy_i = 1; b_dat_i = rep(8'h03);
    step(); chk("b_d3", b_dat_o, rep(8'h03));
    b_vld_i = 0;
    step(); chk("b_empty", b_vld_o, 1'b0); chk("b_cnt", b_cnt, 16'd2);
    b_vld_i = 1; b_dat_i = rep(8'h04);
    step();
    b_flush = 1; b_dat_i = rep(8'h05);
    step(); chk("b_flush_v", b_vld_o, 1'b0);
    b_flush = 0; b_vld_i = 0;
    step(); chk("b_flush_stay", b_vld_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
